// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one downstream memory port between a fetch and a load/store requester.
// Latency: request pulse at edge T issues down_request_enable after edge T+1; one transaction outstanding.
// Backpressure: one slot per side, pulses into a full slot are dropped; ARB_STARVE_GUARD_EN bounds fetch priority.
package mem_arbiter_pkg;
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } memreq_t;

    typedef struct packed {
        logic [31:0] data;
    } memresp_t;
endpackage

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic     clk,
    input  logic     rstn,
    input  logic     fetch_request_enable,
    input  memreq_t  fetch_request,
    output logic     fetch_response_enable,
    output memresp_t fetch_response,
    input  logic     mem_request_enable,
    input  memreq_t  mem_request,
    output logic     mem_response_enable,
    output memresp_t mem_response,
    output logic     down_request_enable,
    output memreq_t  down_request,
    input  logic     down_response_enable,
    input  memresp_t down_response,
    output logic     busy
);
    typedef enum logic {IDLE, WAIT_RESP} state_t;

    state_t  state, state_nxt;
    logic    fetch_vld, mem_vld;
    memreq_t fetch_slot, mem_slot;
    logic    owner_mem;
    logic    grant, grant_mem, done, fetch_done, mem_done, starve;
    logic    fetch_accept, mem_accept;

`ifdef ARB_STARVE_GUARD_EN
    logic [7:0] starve_cnt;

    assign starve = (starve_cnt == 8'(STARVE_LIMIT));

    // Counts fetch wins that overtook a waiting mem request.
    always_ff @(posedge clk) begin
        if (!rstn)
            starve_cnt <= '0;
        else if (grant && grant_mem)
            starve_cnt <= '0;
        else if (grant && mem_vld)
            starve_cnt <= starve_cnt + 8'd1;
    end
`else
    logic unused_limit;
    assign unused_limit = (STARVE_LIMIT == 0);
    assign starve       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rstn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (fetch_vld || mem_vld) state_nxt = WAIT_RESP;
            WAIT_RESP: if (down_response_enable) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        grant      = (state == IDLE) && (fetch_vld || mem_vld);
        grant_mem  = mem_vld && (!fetch_vld || starve);
        done       = (state == WAIT_RESP) && down_response_enable;
        fetch_done = done && !owner_mem;
        mem_done   = done && owner_mem;
    end

    // A pulse on the owner's completion edge refills the slot being freed.
    assign fetch_accept = fetch_request_enable && (!fetch_vld || fetch_done);
    assign mem_accept   = mem_request_enable && (!mem_vld || mem_done);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            fetch_vld <= 1'b0;
            mem_vld   <= 1'b0;
        end else begin
            if (fetch_accept)
                fetch_vld <= 1'b1;
            else if (fetch_done)
                fetch_vld <= 1'b0;
            if (mem_accept)
                mem_vld <= 1'b1;
            else if (mem_done)
                mem_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (fetch_accept) fetch_slot <= fetch_request;
        if (mem_accept)   mem_slot   <= mem_request;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            down_request_enable   <= 1'b0;
            fetch_response_enable <= 1'b0;
            mem_response_enable   <= 1'b0;
            owner_mem             <= 1'b0;
        end else begin
            down_request_enable   <= grant;
            fetch_response_enable <= fetch_done;
            mem_response_enable   <= mem_done;
            if (grant)
                owner_mem <= grant_mem;
        end
    end

    // Payload registers only move on grant/completion, so they hold steady in between.
    always_ff @(posedge clk) begin
        if (grant)
            down_request <= grant_mem ? mem_slot : fetch_slot;
        if (fetch_done)
            fetch_response <= down_response;
        if (mem_done)
            mem_response <= down_response;
    end

    assign busy = (state != IDLE) || fetch_vld || mem_vld;
endmodule
